// File: rtl/picodevice_pkg.sv
// Shared constants for the picorv32-to-AXI4-lite bridge: response codes,
// FSM state encoding and default PROT values.
package picodevice_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD      = 3'd1;
    localparam logic [2:0] ST_WR      = 3'd2;
    localparam logic [2:0] ST_WR_POST = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;
    localparam logic [2:0] ST_DRAIN   = 3'd5;

    localparam logic [2:0] PROT_INSTR_DEFAULT = 3'b100;
    localparam logic [2:0] PROT_DATA_DEFAULT  = 3'b000;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
    endfunction

endpackage

// File: rtl/picodevice_bridge_wdog.sv
// Per-transaction watchdog: saturating up-counter that flags expiry on the
// cycle the count is about to reach TIMEOUT_CYCLES. Tied off when 0.
module picodevice_bridge_wdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_wdog;
            assign unused_wdog = &{1'b0, clk, resetn, clear, enable};
            assign expire = 1'b0;
        end else begin : g_on
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
            logic [CW-1:0] count_reg;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    count_reg <= '0;
                end else if (clear) begin
                    count_reg <= '0;
                end else if (enable && (count_reg != LIMIT)) begin
                    count_reg <= count_reg + 1'b1;
                end
            end

            // Saturation keeps expiry asserted if a success at the limit
            // carries the count into a later waiting state.
            assign expire = enable && (count_reg >= (LIMIT - 1'b1));
        end
    endgenerate

endmodule

// File: rtl/picodevice_mem_bridge.sv
// picorv32 native memory port to AXI4-lite master, one transaction in flight,
// with optional posted writes, error capture and a timeout watchdog.
module picodevice_mem_bridge
    import picodevice_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          POSTED_WRITES  = 1,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [2:0]  INSTR_PROT     = PROT_INSTR_DEFAULT,
    parameter logic [2:0]  DATA_PROT      = PROT_DATA_DEFAULT,
    parameter logic [31:0] ERR_RDATA      = 32'h0000_0073
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  mem_valid,
    input  logic                  mem_instr,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,
    output logic                  mem_axi_awvalid,
    input  logic                  mem_axi_awready,
    output logic [ADDR_WIDTH-1:0] mem_axi_awaddr,
    output logic [2:0]            mem_axi_awprot,
    output logic                  mem_axi_wvalid,
    input  logic                  mem_axi_wready,
    output logic [31:0]           mem_axi_wdata,
    output logic [3:0]            mem_axi_wstrb,
    input  logic                  mem_axi_bvalid,
    output logic                  mem_axi_bready,
    input  logic [1:0]            mem_axi_bresp,
    output logic                  mem_axi_arvalid,
    input  logic                  mem_axi_arready,
    output logic [ADDR_WIDTH-1:0] mem_axi_araddr,
    output logic [2:0]            mem_axi_arprot,
    input  logic                  mem_axi_rvalid,
    output logic                  mem_axi_rready,
    input  logic [31:0]           mem_axi_rdata,
    input  logic [1:0]            mem_axi_rresp,
    output logic                  bus_err,
    output logic [ADDR_WIDTH-1:0] bus_err_addr,
    output logic                  bus_err_timeout
);

    logic [2:0]            state_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [31:0]           wdata_reg;
    logic [3:0]            wstrb_reg;
    logic [2:0]            prot_reg;
    logic                  is_read_reg;
    logic                  ar_done_reg;
    logic                  aw_done_reg;
    logic                  w_done_reg;
    logic [31:0]           rdata_reg;
    logic                  mem_ready_reg;
    logic                  bus_err_reg;
    logic [ADDR_WIDTH-1:0] err_addr_reg;
    logic                  err_timeout_reg;

    logic in_drain_rd;
    logic in_drain_wr;
    logic ar_hs, aw_hs, w_hs, r_hs, b_hs;
    logic aw_ok, w_ok;
    logic wd_enable, wd_clear, wd_expire;

    assign in_drain_rd = (state_reg == ST_DRAIN) &&  is_read_reg;
    assign in_drain_wr = (state_reg == ST_DRAIN) && !is_read_reg;

    // Valids stay up in DRAIN until their own handshake, as AXI requires.
    assign mem_axi_arvalid = ((state_reg == ST_RD) || in_drain_rd) && !ar_done_reg;
    assign mem_axi_awvalid = ((state_reg == ST_WR) || in_drain_wr) && !aw_done_reg;
    assign mem_axi_wvalid  = ((state_reg == ST_WR) || in_drain_wr) && !w_done_reg;
    assign mem_axi_rready  = ((state_reg == ST_RD) && ar_done_reg) || in_drain_rd;
    assign mem_axi_bready  = ((state_reg == ST_WR) && aw_done_reg && w_done_reg)
                           || (state_reg == ST_WR_POST) || in_drain_wr;

    assign mem_axi_awaddr = addr_reg;
    assign mem_axi_araddr = addr_reg;
    assign mem_axi_awprot = prot_reg;
    assign mem_axi_arprot = prot_reg;
    assign mem_axi_wdata  = wdata_reg;
    assign mem_axi_wstrb  = wstrb_reg;

    assign mem_ready       = mem_ready_reg;
    assign mem_rdata       = rdata_reg;
    assign bus_err         = bus_err_reg;
    assign bus_err_addr    = err_addr_reg;
    assign bus_err_timeout = err_timeout_reg;

    assign ar_hs = mem_axi_arvalid && mem_axi_arready;
    assign aw_hs = mem_axi_awvalid && mem_axi_awready;
    assign w_hs  = mem_axi_wvalid  && mem_axi_wready;
    assign r_hs  = mem_axi_rvalid  && mem_axi_rready;
    assign b_hs  = mem_axi_bvalid  && mem_axi_bready;
    assign aw_ok = aw_done_reg || aw_hs;
    assign w_ok  = w_done_reg  || w_hs;

    assign wd_clear  = (state_reg == ST_IDLE) && mem_valid;
    assign wd_enable = (state_reg == ST_RD) || (state_reg == ST_WR) || (state_reg == ST_WR_POST);

    picodevice_bridge_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .resetn (resetn),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= ST_IDLE;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            wstrb_reg       <= '0;
            prot_reg        <= '0;
            is_read_reg     <= 1'b0;
            ar_done_reg     <= 1'b0;
            aw_done_reg     <= 1'b0;
            w_done_reg      <= 1'b0;
            rdata_reg       <= '0;
            mem_ready_reg   <= 1'b0;
            bus_err_reg     <= 1'b0;
            err_addr_reg    <= '0;
            err_timeout_reg <= 1'b0;
        end else begin
            mem_ready_reg <= 1'b0;
            bus_err_reg   <= 1'b0;
            if (ar_hs) ar_done_reg <= 1'b1;
            if (aw_hs) aw_done_reg <= 1'b1;
            if (w_hs)  w_done_reg  <= 1'b1;

            case (state_reg)
                ST_IDLE: begin
                    if (mem_valid) begin
                        addr_reg    <= mem_addr;
                        wdata_reg   <= mem_wdata;
                        wstrb_reg   <= mem_wstrb;
                        prot_reg    <= mem_instr ? INSTR_PROT : DATA_PROT;
                        is_read_reg <= (mem_wstrb == 4'd0);
                        ar_done_reg <= 1'b0;
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
                        state_reg   <= (mem_wstrb == 4'd0) ? ST_RD : ST_WR;
                    end
                end
                ST_RD: begin
                    // A response in the expiry cycle wins over the timeout.
                    if (r_hs) begin
                        rdata_reg     <= (mem_axi_rresp == AXI_RESP_OKAY) ? mem_axi_rdata : ERR_RDATA;
                        mem_ready_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                        if (resp_is_err(mem_axi_rresp)) begin
                            bus_err_reg     <= 1'b1;
                            err_addr_reg    <= addr_reg;
                            err_timeout_reg <= 1'b0;
                        end
                    end else if (wd_expire) begin
                        rdata_reg       <= ERR_RDATA;
                        mem_ready_reg   <= 1'b1;
                        bus_err_reg     <= 1'b1;
                        err_addr_reg    <= addr_reg;
                        err_timeout_reg <= 1'b1;
                        state_reg       <= ST_DRAIN;
                    end
                end
                ST_WR: begin
                    if (aw_done_reg && w_done_reg) begin
                        if (b_hs) begin
                            mem_ready_reg <= 1'b1;
                            state_reg     <= ST_DONE;
                            if (resp_is_err(mem_axi_bresp)) begin
                                bus_err_reg     <= 1'b1;
                                err_addr_reg    <= addr_reg;
                                err_timeout_reg <= 1'b0;
                            end
                        end else if (wd_expire) begin
                            mem_ready_reg   <= 1'b1;
                            bus_err_reg     <= 1'b1;
                            err_addr_reg    <= addr_reg;
                            err_timeout_reg <= 1'b1;
                            state_reg       <= ST_DRAIN;
                        end
                    end else if (aw_ok && w_ok && (POSTED_WRITES != 0)) begin
                        mem_ready_reg <= 1'b1;
                        state_reg     <= ST_WR_POST;
                    end else if (wd_expire) begin
                        mem_ready_reg   <= 1'b1;
                        bus_err_reg     <= 1'b1;
                        err_addr_reg    <= addr_reg;
                        err_timeout_reg <= 1'b1;
                        state_reg       <= ST_DRAIN;
                    end
                end
                ST_WR_POST: begin
                    // Core already released; only the error report remains.
                    if (b_hs) begin
                        state_reg <= ST_IDLE;
                        if (resp_is_err(mem_axi_bresp)) begin
                            bus_err_reg     <= 1'b1;
                            err_addr_reg    <= addr_reg;
                            err_timeout_reg <= 1'b0;
                        end
                    end else if (wd_expire) begin
                        bus_err_reg     <= 1'b1;
                        err_addr_reg    <= addr_reg;
                        err_timeout_reg <= 1'b1;
                        state_reg       <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if ((is_read_reg && r_hs) || (!is_read_reg && b_hs)) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_picodevice_mem_bridge.sv
// Directed bench for picodevice_mem_bridge: a table of single-beat accesses
// plus hand-written sequences for posted ordering, errors, timeout and reset.
module tb_picodevice_mem_bridge;

    typedef struct packed {
        logic        wr;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_err_addr;
        logic [2:0]  exp_prot;
    } vec_t;

    localparam int NV = 7;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    // Posted, 16-cycle watchdog instance
    logic        a_ready, a_awvalid, a_wvalid, a_bready, a_arvalid, a_rready, a_err, a_err_to;
    logic [31:0] a_rdata, a_awaddr, a_wdata, a_araddr, a_err_addr;
    logic [2:0]  a_awprot, a_arprot;
    logic [3:0]  a_wstrb;
    // Non-posted, watchdog-disabled instance
    logic        b_ready, b_awvalid, b_wvalid, b_bready, b_arvalid, b_rready, b_err, b_err_to;
    logic [31:0] b_rdata, b_awaddr, b_wdata, b_araddr, b_err_addr;
    logic [2:0]  b_awprot, b_arprot;
    logic [3:0]  b_wstrb;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    picodevice_mem_bridge #(
        .ADDR_WIDTH(32), .POSTED_WRITES(1), .TIMEOUT_CYCLES(16)
    ) dut_a (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(a_ready), .mem_rdata(a_rdata),
        .mem_axi_awvalid(a_awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(a_awaddr),
        .mem_axi_awprot(a_awprot), .mem_axi_wvalid(a_wvalid), .mem_axi_wready(wready),
        .mem_axi_wdata(a_wdata), .mem_axi_wstrb(a_wstrb), .mem_axi_bvalid(bvalid),
        .mem_axi_bready(a_bready), .mem_axi_bresp(bresp), .mem_axi_arvalid(a_arvalid),
        .mem_axi_arready(arready), .mem_axi_araddr(a_araddr), .mem_axi_arprot(a_arprot),
        .mem_axi_rvalid(rvalid), .mem_axi_rready(a_rready), .mem_axi_rdata(rdata),
        .mem_axi_rresp(rresp), .bus_err(a_err), .bus_err_addr(a_err_addr),
        .bus_err_timeout(a_err_to)
    );

    picodevice_mem_bridge #(
        .ADDR_WIDTH(32), .POSTED_WRITES(0), .TIMEOUT_CYCLES(0)
    ) dut_b (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(b_ready), .mem_rdata(b_rdata),
        .mem_axi_awvalid(b_awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(b_awaddr),
        .mem_axi_awprot(b_awprot), .mem_axi_wvalid(b_wvalid), .mem_axi_wready(wready),
        .mem_axi_wdata(b_wdata), .mem_axi_wstrb(b_wstrb), .mem_axi_bvalid(bvalid),
        .mem_axi_bready(b_bready), .mem_axi_bresp(bresp), .mem_axi_arvalid(b_arvalid),
        .mem_axi_arready(arready), .mem_axi_araddr(b_araddr), .mem_axi_arprot(b_arprot),
        .mem_axi_rvalid(rvalid), .mem_axi_rready(b_rready), .mem_axi_rdata(rdata),
        .mem_axi_rresp(rresp), .bus_err(b_err), .bus_err_addr(b_err_addr),
        .bus_err_timeout(b_err_to)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    // Advance to the middle of the next cycle (outputs settled, away from posedge).
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
        tick;
        tick;
        resetn = 1'b1;
        tick;
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [NV];
        vec_t v;
        logic early, lost;

        vecs[0] = '{1'b0, 1'b0, 32'h100,  32'h0,         4'h0, 2'b00, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 32'h0,    3'b000};
        vecs[1] = '{1'b0, 1'b1, 32'h0,    32'h0,         4'h0, 2'b10, 32'h55AA55AA, 32'h00000073, 1'b1, 32'h0,    3'b100};
        vecs[2] = '{1'b0, 1'b0, 32'h1234, 32'h0,         4'h0, 2'b11, 32'h12345678, 32'h00000073, 1'b1, 32'h1234, 3'b000};
        vecs[3] = '{1'b0, 1'b1, 32'h80,   32'h0,         4'h0, 2'b00, 32'h00100093, 32'h00100093, 1'b0, 32'h1234, 3'b100};
        vecs[4] = '{1'b1, 1'b0, 32'h2004, 32'hA5A50F0F,  4'h3, 2'b00, 32'h0,        32'h0,        1'b0, 32'h1234, 3'b000};
        vecs[5] = '{1'b1, 1'b0, 32'h2008, 32'h0BADF00D,  4'hC, 2'b10, 32'h0,        32'h0,        1'b1, 32'h2008, 3'b000};
        vecs[6] = '{1'b0, 1'b0, 32'h10C,  32'h0,         4'h0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h2008, 3'b000};

        do_reset;
        chk("reset_ctrl", {24'd0, a_ready, a_arvalid, a_awvalid, a_wvalid, a_bready, a_rready, a_err, a_err_to}, 32'h0);
        chk("reset_rdata", a_rdata, 32'h0);
        chk("reset_err_addr", a_err_addr, 32'h0);

        // Table: single accesses with an always-ready slave, request at cycle T.
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            mem_valid = 1'b1; mem_instr = v.instr; mem_addr = v.addr; mem_wdata = v.wdata;
            mem_wstrb = v.wr ? v.wstrb : 4'h0;
            awready = 1'b1; wready = 1'b1; arready = 1'b1;
            tick; // T+1
            if (v.wr) begin
                chk($sformatf("v%0d awvalid", i), a_awvalid, 1);
                chk($sformatf("v%0d wvalid", i), a_wvalid, 1);
                chk($sformatf("v%0d awaddr", i), a_awaddr, v.addr);
                chk($sformatf("v%0d wdata", i), a_wdata, v.wdata);
                chk($sformatf("v%0d wstrb", i), a_wstrb, v.wstrb);
                chk($sformatf("v%0d awprot", i), a_awprot, v.exp_prot);
                tick; // T+2
                chk($sformatf("v%0d posted_ready", i), a_ready, 1);
                chk($sformatf("v%0d bready", i), a_bready, 1);
                mem_valid = 1'b0; bvalid = 1'b1; bresp = v.resp;
                tick; // T+3
                bvalid = 1'b0;
                chk($sformatf("v%0d ready_pulse", i), a_ready, 0);
            end else begin
                chk($sformatf("v%0d arvalid", i), a_arvalid, 1);
                chk($sformatf("v%0d araddr", i), a_araddr, v.addr);
                chk($sformatf("v%0d arprot", i), a_arprot, v.exp_prot);
                tick; // T+2
                chk($sformatf("v%0d rready", i), a_rready, 1);
                chk($sformatf("v%0d arvalid_drop", i), a_arvalid, 0);
                rvalid = 1'b1; rdata = v.rdata; rresp = v.resp;
                tick; // T+3
                rvalid = 1'b0;
                chk($sformatf("v%0d ready", i), a_ready, 1);
                chk($sformatf("v%0d rdata", i), a_rdata, v.exp_rdata);
            end
            chk($sformatf("v%0d bus_err", i), a_err, v.exp_err);
            chk($sformatf("v%0d err_addr", i), a_err_addr, v.exp_err_addr);
            chk($sformatf("v%0d err_timeout", i), a_err_to, 0);
            if (!v.wr) begin
                mem_valid = 1'b0;
                tick; // T+4
                chk($sformatf("v%0d ready_pulse", i), a_ready, 0);
            end
        end

        // Posted write with slow W and late B, then a read that must wait for B.
        do_reset;
        mem_valid = 1'b1; mem_addr = 32'h2000; mem_wdata = 32'h12345678; mem_wstrb = 4'hF;
        awready = 1'b1;
        tick; // T+1
        chk("pw awvalid", a_awvalid, 1);
        chk("pw wvalid", a_wvalid, 1);
        tick; // T+2
        awready = 1'b0;
        chk("pw aw_drop", a_awvalid, 0);
        chk("pw w_hold", a_wvalid, 1);
        tick; // T+3
        chk("pw no_early_ready", a_ready, 0);
        tick; // T+4
        wready = 1'b1;
        tick; // T+5
        wready = 1'b0;
        chk("pw ready", a_ready, 1);
        chk("pw bready", a_bready, 1);
        chk("pw w_drop", a_wvalid, 0);
        mem_valid = 1'b0;
        tick; // T+6
        mem_valid = 1'b1; mem_addr = 32'h300; mem_wstrb = 4'h0; arready = 1'b1;
        for (int k = 6; k <= 9; k++) begin
            chk($sformatf("pw arvalid_blocked_t%0d", k), a_arvalid, 0);
            if (k < 9) tick;
        end
        bvalid = 1'b1; bresp = 2'b00;
        tick; // T+10
        bvalid = 1'b0;
        chk("pw arvalid_t10", a_arvalid, 0);
        chk("pw no_err", a_err, 0);
        tick; // T+11
        chk("pw arvalid_t11", a_arvalid, 1);
        chk("pw araddr", a_araddr, 32'h300);
        tick; // T+12
        rvalid = 1'b1; rdata = 32'h600DF00D; rresp = 2'b00;
        tick; // T+13
        rvalid = 1'b0;
        chk("pw rd_ready", a_ready, 1);
        chk("pw rd_rdata", a_rdata, 32'h600DF00D);
        mem_valid = 1'b0;

        // Non-posted write with DECERR: completion waits for B and reports the error.
        do_reset;
        mem_valid = 1'b1; mem_addr = 32'h3000; mem_wdata = 32'hDEADBEEF; mem_wstrb = 4'h3;
        awready = 1'b1; wready = 1'b1;
        tick; // T+1
        chk("np awvalid", b_awvalid, 1);
        chk("np wvalid", b_wvalid, 1);
        tick; // T+2
        chk("np not_ready", b_ready, 0);
        chk("np bready", b_bready, 1);
        bvalid = 1'b1; bresp = 2'b11;
        tick; // T+3
        bvalid = 1'b0;
        chk("np ready", b_ready, 1);
        chk("np bus_err", b_err, 1);
        chk("np err_addr", b_err_addr, 32'h3000);
        chk("np err_timeout", b_err_to, 0);
        mem_valid = 1'b0;
        tick; // T+4
        chk("np ready_pulse", b_ready, 0);

        // Read timeout: arready withheld until cycle T+40.
        do_reset;
        mem_valid = 1'b1; mem_addr = 32'h400; mem_wstrb = 4'h0;
        tick; // T+1
        early = 1'b0;
        lost  = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (a_ready) early = 1'b1;
            tick;
        end
        // Now at T+17: completion one cycle after the 16th waiting cycle.
        chk("to no_early_ready", early, 0);
        chk("to ready", a_ready, 1);
        chk("to rdata", a_rdata, 32'h73);
        chk("to bus_err", a_err, 1);
        chk("to err_timeout", a_err_to, 1);
        chk("to err_addr", a_err_addr, 32'h400);
        mem_valid = 1'b0;
        tick; // T+18
        chk("to ready_pulse", a_ready, 0);
        for (int k = 18; k <= 39; k++) begin
            if (!a_arvalid) lost = 1'b1;
            tick;
        end
        // T+40
        chk("to arvalid_held", {31'd0, lost | ~a_arvalid}, 0);
        arready = 1'b1;
        tick; // T+41
        arready = 1'b0;
        chk("to arvalid_drop", a_arvalid, 0);
        chk("to drain_rready", a_rready, 1);
        rvalid = 1'b1; rdata = 32'hBADBAD00; rresp = 2'b00;
        tick; // T+42
        rvalid = 1'b0;
        chk("to late_no_ready", a_ready, 0);
        chk("to late_discarded", a_rdata, 32'h73);
        mem_valid = 1'b1; mem_addr = 32'h404; arready = 1'b1;
        tick; // T+43
        chk("to next_arvalid", a_arvalid, 1);
        tick; // T+44
        rvalid = 1'b1; rdata = 32'h11112222;
        tick; // T+45
        rvalid = 1'b0;
        chk("to next_ready", a_ready, 1);
        chk("to next_rdata", a_rdata, 32'h11112222);
        chk("to next_no_err", a_err, 0);
        mem_valid = 1'b0;

        // Asynchronous reset while a write is in flight.
        do_reset;
        mem_valid = 1'b1; mem_addr = 32'h500; mem_wdata = 32'h0F0F0F0F; mem_wstrb = 4'hF;
        tick; // T+1
        chk("rst awvalid_before", a_awvalid, 1);
        #2 resetn = 1'b0;
        #1;
        chk("rst async_valids", {30'd0, a_awvalid, a_wvalid}, 0);
        chk("rst async_ready", a_ready, 0);
        mem_valid = 1'b0;
        tick;
        tick;
        resetn = 1'b1;
        tick;
        chk("rst idle_ctrl", {26'd0, a_arvalid, a_awvalid, a_wvalid, a_bready, a_rready, a_ready}, 0);
        mem_valid = 1'b1; mem_addr = 32'h600; mem_wstrb = 4'h0; arready = 1'b1;
        tick; // T+1
        chk("rst rd_arvalid", a_arvalid, 1);
        tick; // T+2
        rvalid = 1'b1; rdata = 32'h0A0B0C0D; rresp = 2'b00;
        tick; // T+3
        rvalid = 1'b0;
        chk("rst rd_ready", a_ready, 1);
        chk("rst rd_rdata", a_rdata, 32'h0A0B0C0D);
        mem_valid = 1'b0;
        tick;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
